// File: rtl/display_scan_if.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_if
// Description : Bus between the datapath and the display scanner. Carries the
//               load strobe and value in, and the scanned nibble, digit enables
//               and frame strobe out.
// Revision    : 1.0  initial release
// ============================================================================
interface display_scan_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                    load;
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [3:0]              nibble;
    logic [NUM_DIGITS-1:0]   digit_en_n;
    logic                    frame_done;

    // Datapath side: supplies values, observes the scan.
    modport master (
        output load, data_in,
        input  nibble, digit_en_n, frame_done
    );

    // Scanner side.
    modport slave (
        input  load, data_in,
        output nibble, digit_en_n, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_mux
// Description : Time-multiplexed scanner for a common-anode 7-segment bank.
//               Double-buffered load (shadow -> display at frame boundary),
//               registered nibble / active-low digit enable outputs, optional
//               leading-zero blanking.
// Revision    : 1.0  initial release
// ============================================================================
module display_scan_mux #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    display_scan_if.slave   bus
);
    localparam int c_idx_w = (NUM_DIGITS  > 1) ? $clog2(NUM_DIGITS)  : 1;
    localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_one      = NUM_DIGITS'(1);

    logic [c_cnt_w-1:0]      r_cnt;
    logic [c_idx_w-1:0]      r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic                    r_pending;
    logic [3:0]              r_nibble;
    logic [NUM_DIGITS-1:0]   r_digit_en_n;
    logic                    r_frame_done;

    logic                    w_tick;
    logic                    w_wrap;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [NUM_DIGITS-1:0]   w_onehot;

    assign w_tick   = (r_cnt == c_cnt_last);
    assign w_wrap   = w_tick && (r_idx == c_idx_last);
    assign w_onehot = c_one << r_idx;

    // Prescaler: sets how long each digit stays lit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_cnt <= '0;
        else if (w_tick) r_cnt <= '0;
        else             r_cnt <= r_cnt + c_cnt_w'(1);
    end

    // Digit index: steps once per tick, wrap edge is the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_idx <= '0;
        else if (w_wrap)               r_idx <= '0;
        else if (w_tick)               r_idx <= r_idx + c_idx_w'(1);
    end

    // Double buffer: loads land in shadow; display copies it only at the
    // frame boundary, so a frame in progress never mixes two values. A load
    // on the boundary edge itself stays pending for the following frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_disp    <= '0;
            r_pending <= 1'b0;
        end else begin
            if (bus.load)               r_shadow <= bus.data_in;
            if (w_wrap && r_pending)    r_disp   <= r_shadow;
            if (bus.load)               r_pending <= 1'b1;
            else if (w_wrap)            r_pending <= 1'b0;
        end
    end

    // Leading-zero mask: digit i>0 is blank when it and everything above it is zero.
    always_comb begin : p_blank
        logic v_run;
        v_run   = 1'b1;
        w_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            v_run      = v_run & (r_disp[4*i +: 4] == 4'd0);
            w_blank[i] = v_run;
        end
    end

    // Registered outputs, one cycle behind the index; frame strobe follows the wrap edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nibble     <= 4'd0;
            r_digit_en_n <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_nibble     <= r_disp[4*r_idx +: 4];
            r_frame_done <= w_wrap;
            if ((BLANK_LEADING != 0) && w_blank[r_idx]) r_digit_en_n <= '1;
            else                                        r_digit_en_n <= ~w_onehot;
        end
    end

    assign bus.nibble     = r_nibble;
    assign bus.digit_en_n = r_digit_en_n;
    assign bus.frame_done = r_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_display_scan_mux
// Description : Self-checking bench for display_scan_mux (4 digits, divide
//               by 4). Two instances run in lockstep, one without and one with
//               leading-zero blanking; expected scan slots are queued per frame.
// Revision    : 1.0  initial release
// ============================================================================
module tb_display_scan_mux;
    localparam int NUM_DIGITS  = 4;
    localparam int REFRESH_DIV = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    display_scan_if #(.NUM_DIGITS(NUM_DIGITS)) bus_nb ();
    display_scan_if #(.NUM_DIGITS(NUM_DIGITS)) bus_bl ();

    display_scan_mux #(.NUM_DIGITS(NUM_DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_LEADING(0))
        u_dut_nb (.clk(clk), .rst_n(rst_n), .bus(bus_nb));
    display_scan_mux #(.NUM_DIGITS(NUM_DIGITS), .REFRESH_DIV(REFRESH_DIV), .BLANK_LEADING(1))
        u_dut_bl (.clk(clk), .rst_n(rst_n), .bus(bus_bl));

    typedef struct {
        logic [3:0] nib;
        logic [3:0] en_nb;
        logic [3:0] en_bl;
        logic       fd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [3:0] exp_en(logic [15:0] v, int d, bit blank);
        logic [15:0] upper;
        logic [3:0]  sel;
        upper = v >> (4 * d);
        sel   = 4'b0001 << d;
        if (blank && d > 0 && upper == 16'h0) return 4'hF;
        return ~sel;
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(string tag, exp_t e);
        check({tag, " nibble_nb"}, {12'h0, bus_nb.nibble},     {12'h0, e.nib});
        check({tag, " nibble_bl"}, {12'h0, bus_bl.nibble},     {12'h0, e.nib});
        check({tag, " en_nb"},     {12'h0, bus_nb.digit_en_n}, {12'h0, e.en_nb});
        check({tag, " en_bl"},     {12'h0, bus_bl.digit_en_n}, {12'h0, e.en_bl});
        check({tag, " fd_nb"},     {15'h0, bus_nb.frame_done}, {15'h0, e.fd});
        check({tag, " fd_bl"},     {15'h0, bus_bl.frame_done}, {15'h0, e.fd});
    endtask

    task automatic drive_load(logic l, logic [15:0] v);
        bus_nb.load = l; bus_nb.data_in = v;
        bus_bl.load = l; bus_bl.data_in = v;
    endtask

    // Scans one frame showing 'shown'. Called right after the previous frame's
    // frame_done sample (or right after reset release). Loads are issued after
    // sample ls1 / ls2; a load after sample 15 lands on the boundary edge.
    task automatic run_frame(string tag, logic [15:0] shown, int nsamp,
                             int ls1, logic [15:0] lv1, int ls2, logic [15:0] lv2);
        exp_t e;
        for (int s = 1; s <= nsamp; s++) begin
            int d;
            d       = (s - 1) / REFRESH_DIV;
            e.nib   = shown[4*d +: 4];
            e.en_nb = exp_en(shown, d, 1'b0);
            e.en_bl = exp_en(shown, d, 1'b1);
            e.fd    = (s == NUM_DIGITS * REFRESH_DIV);
            exp_q.push_back(e);
        end
        for (int s = 1; s <= nsamp; s++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_outputs($sformatf("%s s%0d", tag, s), e);
            if (s == ls1)      drive_load(1'b1, lv1);
            else if (s == ls2) drive_load(1'b1, lv2);
            else               drive_load(1'b0, 16'h0);
        end
    endtask

    initial begin
        exp_t rst_e;
        rst_e.nib = 4'h0; rst_e.en_nb = 4'hF; rst_e.en_bl = 4'hF; rst_e.fd = 1'b0;
        drive_load(1'b0, 16'h0);

        // Reset held: outputs idle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs($sformatf("reset%0d", i), rst_e);
        end
        rst_n = 1'b1;

        // First frame shows zero; load 1A3F mid-frame
        run_frame("f0_zero", 16'h0000, 16, 3, 16'h1A3F, -1, 16'h0);
        // 1A3F scans; load 1234 while idx=1, must not tear
        run_frame("f1_1A3F", 16'h1A3F, 16, 5, 16'h1234, -1, 16'h0);
        run_frame("f2_1234", 16'h1234, 16, 6, 16'h0050, -1, 16'h0);
        // Blanking patterns
        run_frame("f3_0050", 16'h0050, 16, 1, 16'h0000, -1, 16'h0);
        // Multiple loads; second on the boundary edge
        run_frame("f4_0000", 16'h0000, 16, 2, 16'h1111, 15, 16'h2222);
        run_frame("f5_1111", 16'h1111, 16, -1, 16'h0, -1, 16'h0);
        run_frame("f6_2222", 16'h2222, 16, -1, 16'h0, -1, 16'h0);
        // Partial frame up to idx=2 with a pending load, then async reset
        run_frame("f7_part", 16'h2222, 9, 2, 16'h5678, -1, 16'h0);
        #2 rst_n = 1'b0;
        #1 check_outputs("async_reset", rst_e);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_outputs($sformatf("reset_hold%0d", i), rst_e);
        end
        rst_n = 1'b1;
        // Restart from digit 0; pending load was discarded
        run_frame("f8_rst", 16'h0000, 16, -1, 16'h0, -1, 16'h0);
        run_frame("f9_rst", 16'h0000, 16, -1, 16'h0, -1, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
